// File: rtl/spi_send_only_if.sv
// Handshake and SPI pin bundle for spi_send_only.
// master = upstream requester side, slave = the serialiser itself.
interface spi_send_only_if #(
    parameter int WORD_W = 16
);
    logic                  start;
    logic [WORD_W-1:0]     p1_in;
    logic [WORD_W-1:0]     p2_in;
    logic                  sdi;
    logic                  busy;
    logic                  done;
    logic                  sck;
    logic                  sdo;
    logic                  load;
    logic [2*WORD_W-1:0]   rx_data;

    modport master (
        output start, p1_in, p2_in, sdi,
        input  busy, done, sck, sdo, load, rx_data
    );

    modport slave (
        input  start, p1_in, p2_in, sdi,
        output busy, done, sck, sdo, load, rx_data
    );
endinterface

// File: rtl/spi_send_only.sv
// SPI initiator: sends {p1, p2} MSB first on sck/sdo, framed by load.
// Optional sdi readback into rx_data is enabled by SPI_SEND_READBACK_EN.
module spi_send_only #(
    parameter int WORD_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            areset,
    spi_send_only_if.slave  bus
);
    localparam int FW    = 2 * WORD_W;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FW);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [FW-1:0]     shreg_q, shreg_d;
    logic              sck_q, sck_d;
    logic              sdo_q, sdo_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sck_d   = sck_q;
        sdo_d   = sdo_q;
        load_d  = load_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    shreg_d = {bus.p1_in, bus.p2_in};
                    sdo_d   = bus.p1_in[WORD_W-1];
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                    div_d   = DIV_LAST;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (div_q == '0) begin
                    state_d = SHIFT_HI;
                    sck_d   = 1'b1;
                    div_d   = DIV_LAST;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_q == '0) begin
                    state_d = SHIFT_LO;
                    sck_d   = 1'b0;
                    div_d   = DIV_LAST;
                    // The last bit stays on sdo through HOLD.
                    if (bit_q != BIT_LAST) begin
                        shreg_d = {shreg_q[FW-2:0], 1'b0};
                        sdo_d   = shreg_q[FW-2];
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            SHIFT_LO: begin
                if (div_q == '0) begin
                    div_d = DIV_LAST;
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SHIFT_HI;
                        sck_d   = 1'b1;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            HOLD: begin
                if (div_q == '0) begin
                    state_d = IDLE;
                    load_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sdo_d   = 1'b0;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sck  = sck_q;
    assign bus.sdo  = sdo_q;
    assign bus.load = load_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef SPI_SEND_READBACK_EN
    logic [FW-1:0] rx_sh_q, rx_sh_d;
    logic [FW-1:0] rx_data_q, rx_data_d;

    // sdi is taken on the edge that raises sck, i.e. when the receiver samples.
    always_comb begin
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        if (sck_d && !sck_q) rx_sh_d = {rx_sh_q[FW-2:0], bus.sdi};
        if (done_d)          rx_data_d = rx_sh_q;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rx_sh_q   <= '0;
            rx_data_q <= '0;
        end else begin
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign bus.rx_data = rx_data_q;
`else
    logic unused_sdi;
    assign unused_sdi  = bus.sdi;
    assign bus.rx_data = '0;
`endif
endmodule

// File: tb/tb_spi_send_only.sv
// Directed bench for spi_send_only: CLK_DIV=4 and CLK_DIV=1 instances side by side.
module tb_spi_send_only;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_send_only_if #(.WORD_W(16)) b4 ();
    spi_send_only_if #(.WORD_W(16)) b1 ();
    assign b4.sdi = b4.sdo;
    assign b1.sdi = b1.sdo;

    spi_send_only #(.WORD_W(16), .CLK_DIV(4)) u4 (.clk(clk), .areset(rst_n), .bus(b4));
    spi_send_only #(.WORD_W(16), .CLK_DIV(1)) u1 (.clk(clk), .areset(rst_n), .bus(b1));

    int n_run  = 0;
    int n_fail = 0;

    // Free-running frame monitors; the stimulus reads differences between snapshots.
    int ld4 = 0, re4 = 0, dn4 = 0, ld1 = 0, re1 = 0;
    logic [31:0] sh4 = '0, sh1 = '0;
    logic pk4 = 1'b0, pk1 = 1'b0;
    always @(negedge clk) begin
        if (b4.load) ld4++;
        if (b4.done) dn4++;
        if (b4.sck && !pk4) begin re4++; sh4 = {sh4[30:0], b4.sdo}; end
        pk4 = b4.sck;
        if (b1.load) ld1++;
        if (b1.sck && !pk1) begin re1++; sh1 = {sh1[30:0], b1.sdo}; end
        pk1 = b1.sck;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input bit slow, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (slow ? b4.done : b1.done) begin ok = 1'b1; break; end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    int r0, l0, d0;
    logic [31:0] exp_rx;

    initial begin
        rst_n = 1'b0;
        b4.start = 1'b0; b4.p1_in = '0; b4.p2_in = '0;
        b1.start = 1'b0; b1.p1_in = '0; b1.p2_in = '0;
        cyc(3);
        chk("reset_pins", {b4.sck, b4.sdo, b4.load, b4.busy, b4.done}, 64'd0);
        chk("reset_rx", b4.rx_data, 64'd0);
        rst_n = 1'b1;
        cyc(2);

        // single frame
        r0 = re4; l0 = ld4; d0 = dn4;
        b4.p1_in = 16'h0ABC; b4.p2_in = 16'h0123; b4.start = 1'b1;
        cyc(1);
        b4.start = 1'b0;
        chk("first_cycle", {b4.load, b4.busy, b4.sck, b4.sdo}, 64'b1100);
        wait_done(1'b1, "single_done_seen");
        chk("done_cycle_pins", {b4.busy, b4.load, b4.sdo}, 64'd0);
        cyc(1);
        chk("done_one_cycle", 64'(b4.done), 64'd0);
        cyc(2);
        chk("single_load_len", 64'(ld4 - l0), 64'd264);
        chk("single_rises", 64'(re4 - r0), 64'd32);
        chk("single_data", sh4, 64'h0ABC0123);
        chk("single_done_cnt", 64'(dn4 - d0), 64'd1);

        // start while busy is ignored
        r0 = re4; d0 = dn4;
        b4.p1_in = 16'h1234; b4.p2_in = 16'h5678; b4.start = 1'b1;
        cyc(1);
        b4.start = 1'b0;
        cyc(49);
        b4.p1_in = 16'hFFFF; b4.start = 1'b1;
        cyc(1);
        b4.start = 1'b0;
        wait_done(1'b1, "busy_done_seen");
        cyc(4);
        chk("busy_data", sh4, 64'h12345678);
        chk("busy_rises", 64'(re4 - r0), 64'd32);
        chk("busy_done_cnt", 64'(dn4 - d0), 64'd1);
        chk("busy_idle_after", 64'(b4.busy), 64'd0);

        // back-to-back with start held high
        l0 = ld4; d0 = dn4;
        b4.p1_in = 16'h0001; b4.p2_in = 16'h0002; b4.start = 1'b1;
        cyc(1);
        b4.p1_in = 16'h0003; b4.p2_in = 16'h0004;
        wait_done(1'b1, "b2b_done1_seen");
        chk("b2b_gap_low", 64'(b4.load), 64'd0);
        chk("b2b_data1", sh4, 64'h00010002);
        cyc(1);
        chk("b2b_reload", {b4.load, b4.busy}, 64'b11);
        b4.start = 1'b0;
        wait_done(1'b1, "b2b_done2_seen");
        chk("b2b_data2", sh4, 64'h00030004);
        cyc(2);
        chk("b2b_load_len", 64'(ld4 - l0), 64'd528);
        chk("b2b_done_cnt", 64'(dn4 - d0), 64'd2);

        // reset mid-frame after 10 rising edges
        r0 = re4;
        b4.p1_in = 16'hAAAA; b4.p2_in = 16'h5555; b4.start = 1'b1;
        cyc(1);
        b4.start = 1'b0;
        for (int i = 0; i < 200 && (re4 - r0) < 10; i++) begin
            cyc(1);
            #1;
        end
        chk("mid_rises", 64'(re4 - r0), 64'd10);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_pins", {b4.sck, b4.sdo, b4.load, b4.busy, b4.done}, 64'd0);
        d0 = dn4;
        cyc(3);
        #1 rst_n = 1'b1;
        cyc(2);
        chk("mid_no_done", 64'(dn4 - d0), 64'd0);

        // fresh frame after reset; readback when the option is built in
        r0 = re4;
        b4.p1_in = 16'h0ABC; b4.p2_in = 16'h0123; b4.start = 1'b1;
        cyc(1);
        b4.start = 1'b0;
        wait_done(1'b1, "fresh_done_seen");
`ifdef SPI_SEND_READBACK_EN
        exp_rx = 32'h0ABC0123;
`else
        exp_rx = 32'h0;
`endif
        chk("fresh_rx_data", b4.rx_data, 64'(exp_rx));
        chk("fresh_data", sh4, 64'h0ABC0123);
        chk("fresh_rises", 64'(re4 - r0), 64'd32);

        // CLK_DIV=1 instance
        r0 = re1; l0 = ld1;
        b1.p1_in = 16'h8000; b1.p2_in = 16'h0001; b1.start = 1'b1;
        cyc(1);
        b1.start = 1'b0;
        cyc(1);
        chk("div1_sck_first", 64'(b1.sck), 64'd1);
        cyc(1);
        chk("div1_sck_toggle", 64'(b1.sck), 64'd0);
        wait_done(1'b0, "div1_done_seen");
        cyc(2);
        chk("div1_load_len", 64'(ld1 - l0), 64'd66);
        chk("div1_rises", 64'(re1 - r0), 64'd32);
        chk("div1_data", sh1, 64'h80000001);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_send_only.md
Name: spi_send_only

Overview:
- FPGA-side SPI initiator that serialises two 16-bit words (p1, p2) onto sck/sdo, framed by an active-high load strobe.
- Wire-compatible with spi_receive_only, the existing frame receiver.
- Used for FPGA-to-FPGA sample forwarding and for on-board loopback testing of the receive path without the MCU.
- Driven by the internal oscillator clock; upstream logic hands over words with a start/busy/done handshake.

Parameters:
WORD_W, 16, width of each word; frame is 2*WORD_W bits, p1 first.
CLK_DIV, 4, clk cycles per sck half-period; minimum 1.

Ports:
clk  input  1  system clock (oscillator)
areset  input  1  asynchronous active-low reset
start  input  1  request to send; sampled only in IDLE
p1_in  input  WORD_W  first word, captured on accepted start
p2_in  input  WORD_W  second word, captured on accepted start
sdi  input  1  receiver's sdo echo; used only with the optional feature
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame end
sck  output  1  SPI clock, idle low
sdo  output  1  serial data, MSB first
load  output  1  frame strobe, high for the whole frame
rx_data  output  2*WORD_W  readback word; optional feature only

Behaviour:
- Reset (areset=0, async): state IDLE; sck=0, sdo=0, load=0, busy=0, done=0, rx_data=0, shift register and counters cleared. Reset mid-frame aborts immediately with no done pulse.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD.
- IDLE: on start=1, capture frame = {p1_in, p2_in}. Next cycle: SETUP, load=1, busy=1, sdo=frame[2*WORD_W-1].
- SETUP: lasts CLK_DIV cycles, with sck=0 and sdo stable. Then go to SHIFT_HI.
- SHIFT_HI: sck=1 for CLK_DIV cycles; the receiver samples sdo on this rising edge. Then go to SHIFT_LO.
- SHIFT_LO: sck=0 for CLK_DIV cycles.
  - sdo advances to the next bit on the same cycle sck falls.
  - After the last bit's low phase, go to HOLD; otherwise go to SHIFT_HI.
  - After the last bit, sdo holds the LSB.
- HOLD: sck=0 and load=1 for CLK_DIV cycles. Then return to IDLE, with load=0, busy=0, done=1 for exactly that one cycle, and sdo=0.
- load high duration is (2 + 4*WORD_W)*CLK_DIV cycles: 264 for the defaults. The frame has exactly 2*WORD_W sck rising edges.
- start while busy=1 is ignored; the frame being sent is unaffected. p1_in/p2_in changes after capture are ignored.
- start asserted on the done cycle (state IDLE) is accepted. load is then low for exactly that one cycle before rising again.
- Bit counter covers 0..2*WORD_W-1 with no wrap past the last bit. Divider counter reloads at each phase boundary.
- CLK_DIV=1 is legal: sck toggles every clk cycle.

Optional Feature:
- Macro SPI_SEND_READBACK_EN.
- Defined:
  - sdi is sampled on each cycle sck rises and shifted MSB-first into an internal register.
  - rx_data updates from that register in the done cycle and holds until the next done or reset.
- Undefined:
  - sdi is unused and rx_data is tied to 0.
  - No readback logic is synthesised.

Test Plan:
- Single frame: p1_in=16'h0ABC, p2_in=16'h0123, start pulse, CLK_DIV=4 -> load high 264 cycles; 32 sck rising edges; sdo at rising edges = 32'h0ABC0123 MSB first; done is one cycle when load falls; busy drops on the same cycle.
- Start during busy: start at frame cycle 50 with p1_in=16'hFFFF -> ignored; transmitted frame unchanged; exactly one done.
- Back-to-back: start held high continuously, frames 32'h00010002 then 32'h00030004 -> load low for exactly 1 cycle between frames; both frames correct.
- Reset mid-frame: areset=0 after 10 sck edges -> sck, sdo, load, busy all 0 immediately; no done; next start sends a full fresh frame.
- CLK_DIV=1 build: frame 32'h80000001 -> sck toggles every cycle; load high 66 cycles; first and last sampled bits are 1, the rest 0.
- SPI_SEND_READBACK_EN defined, sdi tied to sdo -> rx_data = 32'h0ABC0123 in the done cycle.
